// File: rtl/mips_mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package mips_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Operations that take the multi-cycle iteration path.
  function automatic logic is_run_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring shift-subtract divide
// over the {acc, shreg} pair.
module mips_mdu_step
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] shreg_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply consumes the multiplier LSB-first from shreg while product bits fill it from the top;
  // divide shifts dividend bits into acc and shifts quotient bits into shreg from the bottom.
  always_comb begin
    sum       = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    shifted   = {acc, shreg[WIDTH-1]};
    ge        = shifted >= {1'b0, operand};
    diff      = shifted[WIDTH-1:0] - operand;
    acc_nxt   = sum[WIDTH:1];
    shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt   = ge ? diff : shifted[WIDTH-1:0];
      shreg_nxt = {shreg[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/mips_mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Define MIPS_MDU_SIGNED_EN to give MULT/DIV signed semantics; otherwise they act as MULTU/DIVU.
module mips_mdu_iter
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, shreg_q, operand_q;
  logic [WIDTH-1:0] acc_nxt, shreg_nxt;
  logic             is_div_q, bz_q;
  logic             accept, write_hi, write_lo;
  logic             run_op, div_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign run_op = is_run_op(op);
  assign div_op = is_div_op(op);
  assign prod   = {acc_nxt, shreg_nxt};
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  mips_mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .acc       (acc_q),
    .shreg     (shreg_q),
    .operand   (operand_q),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

`ifdef MIPS_MDU_SIGNED_EN
  logic signed_op, a_neg, b_neg, neg_res_q, neg_rem_q;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign prod_fix  = neg_res_q ? -prod : prod;
  assign quo_fix   = neg_res_q ? -shreg_nxt : shreg_nxt;
  assign rem_fix   = neg_rem_q ? -acc_nxt : acc_nxt;

  // Result signs are fixed at accept so the iteration itself stays purely unsigned.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end
  end
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign prod_fix = prod;
  assign quo_fix  = shreg_nxt;
  assign rem_fix  = acc_nxt;
`endif

  // DONE behaves like IDLE for new requests so back-to-back operations need no bubble.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    write_hi  = 1'b0;
    write_lo  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (start) begin
          if (run_op) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else if (op == OP_MTHI) begin
            write_hi = 1'b1;
          end else if (op == OP_MTLO) begin
            write_lo = 1'b1;
          end
        end
      end
      RUN:     if (cnt_q == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      bz_q      <= 1'b0;
      dbz       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc_q     <= '0;
        shreg_q   <= div_op ? a_mag : b_mag;
        operand_q <= div_op ? b_mag : a_mag;
        is_div_q  <= div_op;
        bz_q      <= div_op && (b == '0);
        cnt_q     <= CNT_W'(WIDTH - 1);
        dbz       <= 1'b0;
      end else if (state == RUN) begin
        acc_q   <= acc_nxt;
        shreg_q <= shreg_nxt;
        cnt_q   <= cnt_q - CNT_W'(1);
        // HI/LO only change on the final iteration edge, so MFHI/MFLO see old values during RUN.
        if (cnt_q == '0) begin
          dbz <= bz_q;
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= bz_q ? '1 : quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
      end
      if (write_hi) hi <= a;
      if (write_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mips_mdu_iter.sv
// Randomised scoreboard bench for mips_mdu_iter at WIDTH=32; the reference model uses plain
// 64-bit arithmetic and follows MIPS_MDU_SIGNED_EN the same way the design does.
module tb_mips_mdu_iter;
  import mips_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           issue;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           vectors = 0;
  int           miscompares = 0;
  int           busy_run = 0;
  int           cyc = 0;
  logic [W-1:0] model_hi, model_lo;
  logic         last_dbz;

  mips_mdu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results straight from the arithmetic definition of each operation.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t        e;
    longint      sa, sbv, q, r, p;
    logic        signed_op;
`ifdef MIPS_MDU_SIGNED_EN
    signed_op = (o == OP_MULT) || (o == OP_DIV);
`else
    signed_op = 1'b0;
`endif
    sa      = signed_op ? longint'($signed(av)) : longint'(av);
    sbv     = signed_op ? longint'($signed(bv)) : longint'(bv);
    e.dbz   = 1'b0;
    e.issue = 0;
    if (o == OP_MULT || o == OP_MULTU) begin
      p    = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (bv == '0) begin
      e.lo  = '1;
      e.hi  = av;
      e.dbz = 1'b1;
    end else begin
      q    = sa / sbv;
      r    = sa % sbv;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a falling edge; issues one request and leaves the bench at the next falling edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic is_run;
    is_run = (o <= 3'd3);
    start  = 1'b1;
    op     = o;
    a      = av;
    b      = bv;
    if (is_run) begin
      e        = model(o, av, bv);
      e.issue  = cyc;
      sb.push_back(e);
      model_hi = e.hi;
      model_lo = e.lo;
      last_dbz = e.dbz;
    end else if (o == OP_MTHI) begin
      model_hi = av;
    end else if (o == OP_MTLO) begin
      model_lo = av;
    end
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    a     = 32'($urandom);
    b     = 32'($urandom);
    if (is_run) begin
      checkOutput("run_busy", 64'(busy), 64'd1);
      checkOutput("dbz_clear", 64'(dbz), 64'd0);
    end else begin
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_done", 64'(done), 64'd0);
      checkOutput("idle_hi", 64'(hi), 64'(model_hi));
      checkOutput("idle_lo", 64'(lo), 64'(model_lo));
      checkOutput("dbz_hold", 64'(dbz), 64'(last_dbz));
    end
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("res_hi", 64'(hi), 64'(mon_e.hi));
          checkOutput("res_lo", 64'(lo), 64'(mon_e.lo));
          checkOutput("res_dbz", 64'(dbz), 64'(mon_e.dbz));
          checkOutput("latency", 64'(cyc), 64'(mon_e.issue + W + 1));
          checkOutput("busy_cycles", 64'(busy_run), 64'(W));
          busy_run = 0;
        end
      end
    end
  end

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    reset    = 1'b1;
    start    = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    model_hi = '0;
    model_lo = '0;
    last_dbz = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_dbz", 64'(dbz), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone();
    @(negedge clk);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    waitDone();
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitDone();
    @(negedge clk);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone();
    @(negedge clk);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone();
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd5, 32'd0);
    waitDone();
    @(negedge clk);
    applyStimulus(OP_MTHI, 32'h1234, 32'd0);
    applyStimulus(OP_MTLO, 32'h5678, 32'd0);
    applyStimulus(OP_MULTU, 32'd3, 32'd4);
    waitDone();
    @(negedge clk);
    applyStimulus(3'd6, 32'hAAAA_5555, 32'd1);
    applyStimulus(3'd7, 32'h5555_AAAA, 32'd2);

    // A second request during RUN must be dropped, not queued.
    applyStimulus(OP_MULTU, 32'hDEAD_BEEF, 32'h0123_4567);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    @(negedge clk);

    // Reset on the tenth RUN cycle abandons the operation.
    applyStimulus(OP_MULTU, 32'h0000_FFFF, 32'h0001_0001);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    reset    = 1'b0;
    model_hi = '0;
    model_lo = '0;
    last_dbz = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = randOperand();
      rb = randOperand();
      applyStimulus(ro, ra, rb);
      if (ro <= 3'd3) begin
        waitDone();
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end

    repeat (40) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
